// File: rtl/brightness_contrast_adj_pkg.sv
// rtl/brightness_contrast_adj_pkg.sv - mode encoding and config defaults for the pixel adjuster
package brightness_contrast_adj_pkg;

    typedef enum logic [1:0] {
        MODE_BYPASS = 2'd0,
        MODE_OFFSET = 2'd1,
        MODE_GAIN   = 2'd2,
        MODE_INVERT = 2'd3
    } mode_e;

    localparam int DEFAULT_OFFSET = 0;

    // Unity gain in unsigned fixed point with frac_w fractional bits.
    function automatic int unsigned default_gain(input int unsigned frac_w);
        return 32'd1 << frac_w;
    endfunction

endpackage

// File: rtl/brightness_contrast_adj_if.sv
// rtl/brightness_contrast_adj_if.sv - pixel input and output stream handshake bundle
interface brightness_contrast_adj_if #(
    parameter int DATA_W   = 8,
    parameter int CHANNELS = 3
);
    logic                         s_valid;
    logic                         s_ready;
    logic [CHANNELS*DATA_W-1:0]   s_data;
    logic                         s_sof;
    logic                         s_eol;
    logic                         m_valid;
    logic                         m_ready;
    logic [CHANNELS*DATA_W-1:0]   m_data;
    logic                         m_sof;
    logic                         m_eol;

    // master drives pixels in and consumes results; slave is the adjuster
    modport master (
        output s_valid, s_data, s_sof, s_eol, m_ready,
        input  s_ready, m_valid, m_data, m_sof, m_eol
    );

    modport slave (
        input  s_valid, s_data, s_sof, s_eol, m_ready,
        output s_ready, m_valid, m_data, m_sof, m_eol
    );
endinterface

// File: rtl/brightness_contrast_adj_channel.sv
// rtl/brightness_contrast_adj_channel.sv - one colour sample: gain stage then offset/invert with clamp
module bca_channel
    import brightness_contrast_adj_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int FRAC_W = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              en_i,
    input  mode_e             mode_i,
    input  logic [DATA_W-1:0] gain_i,
    input  logic [DATA_W-1:0] x_i,
    input  mode_e             s1_mode_i,
    input  logic [DATA_W:0]   s1_offset_i,
    output logic [DATA_W-1:0] y_o,
    output logic              clip_o
);
    localparam int P_W = 2*DATA_W + 1;
    localparam int Y_W = P_W + 2;
    localparam logic [P_W-1:0]        HALF  = P_W'(1) << (FRAC_W - 1);
    localparam logic signed [Y_W-1:0] MAX_Y = Y_W'((1 << DATA_W) - 1);

    logic [P_W-1:0]        prod;
    logic [P_W-1:0]        p_d, p_q;
    logic signed [Y_W-1:0] p_s, off_s, y_w;
    logic [DATA_W-1:0]     y_d, y_q;

    assign prod = P_W'(x_i) * P_W'(gain_i) + HALF;

    always_comb begin
        p_d = P_W'(x_i);
        if (mode_i == MODE_GAIN) begin
            p_d = prod >> FRAC_W;
        end
    end

    assign p_s   = Y_W'(p_q);
    assign off_s = {{(Y_W-DATA_W-1){s1_offset_i[DATA_W]}}, s1_offset_i};

    always_comb begin
        y_w = p_s;
        case (s1_mode_i)
            MODE_BYPASS: y_w = p_s;
            MODE_OFFSET: y_w = p_s + off_s;
            MODE_GAIN:   y_w = p_s + off_s;
            default:     y_w = MAX_Y - p_s;
        endcase
    end

    always_comb begin
        y_d    = y_w[DATA_W-1:0];
        clip_o = 1'b0;
        if (y_w < 0) begin
            y_d    = '0;
            clip_o = 1'b1;
        end else if (y_w > MAX_Y) begin
            y_d    = '1;
            clip_o = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            p_q <= '0;
            y_q <= '0;
        end else if (en_i) begin
            p_q <= p_d;
            y_q <= y_d;
        end
    end

    assign y_o = y_q;
endmodule

// File: rtl/brightness_contrast_adj.sv
// rtl/brightness_contrast_adj.sv - two-stage brightness/contrast pipeline with per-frame config and clip count
module brightness_contrast_adj
    import brightness_contrast_adj_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int CHANNELS = 3,
    parameter int FRAC_W   = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [1:0]                cfg_mode_i,
    input  logic [DATA_W-1:0]         cfg_gain_i,
    input  logic [DATA_W:0]           cfg_offset_i,
    brightness_contrast_adj_if.slave  bus,
    output logic [31:0]               sat_cnt_o
);
    logic en, accept, load_cfg;

    mode_e              mode_q, mode_d;
    logic [DATA_W-1:0]  gain_q, gain_d;
    logic [DATA_W:0]    offset_q, offset_d;

    logic               s1_valid_q, s1_sof_q, s1_eol_q;
    mode_e              s1_mode_q;
    logic [DATA_W:0]    s1_offset_q;

    logic               m_valid_q, m_sof_q, m_eol_q;
    logic [31:0]        sat_q, sat_d, clip_cnt;
    logic [CHANNELS-1:0] clip;
    logic [CHANNELS*DATA_W-1:0] m_data;

    assign en       = !m_valid_q || bus.m_ready;
    assign accept   = bus.s_valid && en;
    assign load_cfg = accept && bus.s_sof;

    // The s_sof beat itself must already see the freshly loaded config.
    always_comb begin
        mode_d   = load_cfg ? mode_e'(cfg_mode_i) : mode_q;
        gain_d   = load_cfg ? cfg_gain_i : gain_q;
        offset_d = load_cfg ? cfg_offset_i : offset_q;
    end

    always_comb begin
        clip_cnt = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            clip_cnt = clip_cnt + 32'(clip[c]);
        end
    end

    always_comb begin
        sat_d = sat_q;
        if (en && s1_valid_q) begin
            if (s1_sof_q) begin
                sat_d = clip_cnt;
            end else if (sat_q > (32'hFFFF_FFFF - clip_cnt)) begin
                sat_d = 32'hFFFF_FFFF;
            end else begin
                sat_d = sat_q + clip_cnt;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mode_q      <= MODE_BYPASS;
            gain_q      <= DATA_W'(default_gain(FRAC_W));
            offset_q    <= (DATA_W+1)'(DEFAULT_OFFSET);
            s1_valid_q  <= 1'b0;
            s1_sof_q    <= 1'b0;
            s1_eol_q    <= 1'b0;
            s1_mode_q   <= MODE_BYPASS;
            s1_offset_q <= '0;
            m_valid_q   <= 1'b0;
            m_sof_q     <= 1'b0;
            m_eol_q     <= 1'b0;
            sat_q       <= '0;
        end else begin
            mode_q   <= mode_d;
            gain_q   <= gain_d;
            offset_q <= offset_d;
            sat_q    <= sat_d;
            if (en) begin
                s1_valid_q  <= bus.s_valid;
                s1_sof_q    <= bus.s_sof;
                s1_eol_q    <= bus.s_eol;
                s1_mode_q   <= mode_d;
                s1_offset_q <= offset_d;
                m_valid_q   <= s1_valid_q;
                m_sof_q     <= s1_sof_q;
                m_eol_q     <= s1_eol_q;
            end
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        bca_channel #(
            .DATA_W (DATA_W),
            .FRAC_W (FRAC_W)
        ) u_ch (
            .clk_i       (clk_i),
            .rst_i       (rst_i),
            .en_i        (en),
            .mode_i      (mode_d),
            .gain_i      (gain_d),
            .x_i         (bus.s_data[c*DATA_W +: DATA_W]),
            .s1_mode_i   (s1_mode_q),
            .s1_offset_i (s1_offset_q),
            .y_o         (m_data[c*DATA_W +: DATA_W]),
            .clip_o      (clip[c])
        );
    end

    assign bus.s_ready = en;
    assign bus.m_valid = m_valid_q;
    assign bus.m_data  = m_data;
    assign bus.m_sof   = m_sof_q;
    assign bus.m_eol   = m_eol_q;
    assign sat_cnt_o   = sat_q;
endmodule
